// File: rtl/regfile_seq.sv
// Command sequencer for the 8x16 two-read/one-write register file.
// Each accepted command walks IDLE -> READ -> EXEC -> WB and writes one result back.
module regfile_seq #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_rd,
    input  logic [SEL_W-1:0]  cmd_rs,
    input  logic [SEL_W-1:0]  cmd_rt,
    input  logic [IMM_W-1:0]  cmd_imm,
    output logic [SEL_W-1:0]  a_sel,
    output logic [SEL_W-1:0]  b_sel,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] w_data,
    output logic [SEL_W-1:0]  w_sel,
    output logic              w_en,
    output logic              done,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LDI, OP_SHL1
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q;
    logic [SEL_W-1:0]   rd_q;
    logic [IMM_W-1:0]   imm_q;
    logic [SEL_W-1:0]   a_sel_q, b_sel_q, w_sel_q;
    logic [DATA_W-1:0]  w_data_q;
    logic               w_en_q, done_q, flag_z_q, flag_c_q;

    logic               accept;
    logic [DATA_W-1:0]  result_d;
    logic               carry_d;
    logic [DATA_W:0]    sum_w, diff_w;

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign a_sel  = a_sel_q;
    assign b_sel  = b_sel_q;
    assign w_data = w_data_q;
    assign w_sel  = w_sel_q;
    assign w_en   = w_en_q;
    assign done   = done_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The extra top bit of the widened difference is the unsigned borrow.
    assign sum_w  = {1'b0, a_data} + {1'b0, b_data};
    assign diff_w = {1'b0, a_data} - {1'b0, b_data};

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        case (op_q)
            OP_ADD:  begin result_d = sum_w[DATA_W-1:0];  carry_d = sum_w[DATA_W];  end
            OP_SUB:  begin result_d = diff_w[DATA_W-1:0]; carry_d = diff_w[DATA_W]; end
            OP_AND:  result_d = a_data & b_data;
            OP_OR:   result_d = a_data | b_data;
            OP_XOR:  result_d = a_data ^ b_data;
            OP_MOV:  result_d = a_data;
            OP_LDI:  result_d = {{(DATA_W-IMM_W){1'b0}}, imm_q};
            OP_SHL1: begin result_d = {a_data[DATA_W-2:0], 1'b0}; carry_d = a_data[DATA_W-1]; end
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            imm_q    <= '0;
            a_sel_q  <= '0;
            b_sel_q  <= '0;
            w_sel_q  <= '0;
            w_data_q <= '0;
            w_en_q   <= 1'b0;
            done_q   <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Selects are loaded on accept so they are already valid throughout READ.
            if (accept) begin
                op_q    <= op_t'(cmd_op);
                rd_q    <= cmd_rd;
                imm_q   <= cmd_imm;
                a_sel_q <= cmd_rs;
                b_sel_q <= cmd_rt;
            end
            if (state_q == S_EXEC) begin
                w_data_q <= result_d;
                w_sel_q  <= rd_q;
                flag_z_q <= (result_d == '0);
                flag_c_q <= carry_d;
                w_en_q   <= 1'b1;
                done_q   <= 1'b1;
            end else begin
                w_en_q   <= 1'b0;
                done_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural 8x16 register file attached.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
    logic [7:0]  cmd_imm;
    logic [2:0]  a_sel, b_sel, w_sel;
    logic [15:0] a_data, b_data, w_data;
    logic        w_en, done, busy, flag_z, flag_c;

    logic [15:0] rf [8];
    logic        rf_clr;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, MOV = 3'd5, LDI = 3'd6, SHL1 = 3'd7;

    always #5 clk = ~clk;

    regfile_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_imm(cmd_imm), .a_sel(a_sel), .b_sel(b_sel), .a_data(a_data),
        .b_data(b_data), .w_data(w_data), .w_sel(w_sel), .w_en(w_en),
        .done(done), .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
    );

    assign a_data = rf[a_sel];
    assign b_data = rf[b_sel];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (w_en) begin
            rf[w_sel] <= w_data;
        end
    end

    // Issues one command and watches the four cycles after the accept edge.
    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [7:0] imm,
                          output logic [15:0] o_wdata, output logic [2:0] o_wsel,
                          output logic o_done, output logic o_z, output logic o_c,
                          output int o_wen_k, output int o_pulses, output logic [3:0] o_ready);
        int t;
        o_wdata = 'x; o_wsel = 'x; o_done = 1'b0; o_z = 1'bx; o_c = 1'bx;
        o_wen_k = -1; o_pulses = 0; o_ready = '0;
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: cmd_ready=%b, required 1 within 20 cycles", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            o_ready[k-1] = cmd_ready;
            if (w_en) begin
                o_pulses++;
                o_wen_k = k;
                o_wdata = w_data; o_wsel = w_sel; o_done = done;
                o_z = flag_z; o_c = flag_c;
            end
        end
        $display("op=%0d rd=%0d rs=%0d rt=%0d imm=%h -> w_data=%h w_sel=%0d z=%b c=%b wen_cycle=%0d",
                 op, rd, rs, rt, imm, o_wdata, o_wsel, o_z, o_c, o_wen_k);
    endtask

    logic [15:0] r_data;
    logic [2:0]  r_sel;
    logic        r_done, r_z, r_c;
    int          r_k, r_p;
    logic [3:0]  r_ready;

    task automatic test_reset();
        rst = 1'b1; rf_clr = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0; cmd_imm = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, w_en, done, flag_z, flag_c} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/wen/done/z/c=%b, required 000000",
                     {cmd_ready, busy, w_en, done, flag_z, flag_c});
        end
        checks++;
        if ({a_sel, b_sel, w_sel, w_data} !== 25'h0) begin
            errors++;
            $display("FAIL reset_data: a_sel=%0d b_sel=%0d w_sel=%0d w_data=%h, required all 0",
                     a_sel, b_sel, w_sel, w_data);
        end
        rst = 1'b0; rf_clr = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_ldi();
        run_op(LDI, 3'd1, 3'd0, 3'd0, 8'hF0, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_k !== 3 || r_p !== 1) begin
            errors++;
            $display("FAIL ldi_latency: wen_cycle=%0d pulses=%0d, required 3 and 1", r_k, r_p);
        end
        checks++;
        if (r_data !== 16'h00F0 || r_sel !== 3'd1 || r_done !== 1'b1 || r_z !== 1'b0) begin
            errors++;
            $display("FAIL ldi_write: w_data=%h w_sel=%0d done=%b z=%b, required 00f0 1 1 0",
                     r_data, r_sel, r_done, r_z);
        end
        checks++;
        if (r_ready !== 4'b1000) begin
            errors++;
            $display("FAIL ldi_ready: ready(cyc4..1)=%b, required 1000", r_ready);
        end
    endtask

    task automatic test_add_carry();
        run_op(LDI, 3'd2, 3'd0, 3'd0, 8'hFF, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        run_op(LDI, 3'd3, 3'd0, 3'd0, 8'h01, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        repeat (8) run_op(SHL1, 3'd2, 3'd2, 3'd0, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (rf[2] !== 16'hFF00) begin
            errors++;
            $display("FAIL shl1_chain: r2=%h, required ff00", rf[2]);
        end
        run_op(ADD, 3'd4, 3'd2, 3'd3, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_data !== 16'hFF01 || r_sel !== 3'd4 || r_c !== 1'b0 || r_z !== 1'b0) begin
            errors++;
            $display("FAIL add_nocarry: w_data=%h w_sel=%0d z=%b c=%b, required ff01 4 0 0",
                     r_data, r_sel, r_z, r_c);
        end
        run_op(LDI, 3'd5, 3'd0, 3'd0, 8'hFF, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        repeat (8) run_op(SHL1, 3'd5, 3'd5, 3'd0, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        run_op(LDI, 3'd6, 3'd0, 3'd0, 8'hFF, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        run_op(OR_, 3'd5, 3'd5, 3'd6, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL preload_r5: w_data=%h, required ffff", r_data);
        end
        run_op(ADD, 3'd6, 3'd5, 3'd3, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_data !== 16'h0000 || r_z !== 1'b1 || r_c !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: w_data=%h z=%b c=%b, required 0000 1 1", r_data, r_z, r_c);
        end
        run_op(SHL1, 3'd0, 3'd5, 3'd0, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_data !== 16'hFFFE || r_sel !== 3'd0 || r_c !== 1'b1 || rf[0] !== 16'hFFFE) begin
            errors++;
            $display("FAIL shl1_carry_r0: w_data=%h w_sel=%0d c=%b r0=%h, required fffe 0 1 fffe",
                     r_data, r_sel, r_c, rf[0]);
        end
    endtask

    task automatic test_sub();
        run_op(SUB, 3'd7, 3'd3, 3'd2, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_data !== 16'h0101 || r_c !== 1'b1 || r_z !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: w_data=%h z=%b c=%b, required 0101 0 1", r_data, r_z, r_c);
        end
        run_op(SUB, 3'd3, 3'd3, 3'd3, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_data !== 16'h0000 || r_z !== 1'b1 || r_c !== 1'b0 || rf[3] !== 16'h0000) begin
            errors++;
            $display("FAIL sub_alias: w_data=%h z=%b c=%b r3=%h, required 0000 1 0 0000",
                     r_data, r_z, r_c, rf[3]);
        end
    endtask

    task automatic test_back_to_back();
        int acc_k, pulses, t;
        int pk [2];
        logic [15:0] pd [2];
        logic [2:0]  ps [2];
        acc_k = -1; pulses = 0;
        pk[0] = -1; pk[1] = -1; pd[0] = 'x; pd[1] = 'x; ps[0] = 'x; ps[1] = 'x;
        @(negedge clk);
        cmd_op = LDI; cmd_rd = 3'd4; cmd_rs = 3'd0; cmd_rt = 3'd0; cmd_imm = 8'h11;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 cmd_rd = 3'd5; cmd_imm = 8'h22;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (w_en) begin
                if (pulses < 2) begin
                    pk[pulses] = k; pd[pulses] = w_data; ps[pulses] = w_sel;
                end
                pulses++;
            end
            if (cmd_valid && cmd_ready) begin
                acc_k = k;
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        $display("back-to-back: second accept cycle=%0d pulses=%0d", acc_k, pulses);
        checks++;
        if (acc_k !== 4 || pulses !== 2) begin
            errors++;
            $display("FAIL b2b_accept: accept_cycle=%0d pulses=%0d, required 4 and 2", acc_k, pulses);
        end
        checks++;
        if (pk[0] !== 3 || pd[0] !== 16'h0011 || ps[0] !== 3'd4) begin
            errors++;
            $display("FAIL b2b_first: cycle=%0d w_data=%h w_sel=%0d, required 3 0011 4", pk[0], pd[0], ps[0]);
        end
        checks++;
        if (pk[1] !== 7 || pd[1] !== 16'h0022 || ps[1] !== 3'd5) begin
            errors++;
            $display("FAIL b2b_second: cycle=%0d w_data=%h w_sel=%0d, required 7 0022 5", pk[1], pd[1], ps[1]);
        end
        // Restore r5 for the reset test's operands.
        run_op(LDI, 3'd5, 3'd0, 3'd0, 8'hFF, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        run_op(SUB, 3'd5, 3'd3, 3'd5, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (r_data !== 16'hFF01 || r_c !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restore: w_data=%h c=%b, required ff01 1", r_data, r_c);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        @(negedge clk);
        cmd_op = ADD; cmd_rd = 3'd6; cmd_rs = 3'd5; cmd_rt = 3'd5; cmd_imm = 8'h00;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || a_sel !== 3'd5) begin
            errors++;
            $display("FAIL rstmid_read: busy=%b a_sel=%0d, required 1 5", busy, a_sel);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (w_en) stray++;
        checks++;
        if ({cmd_ready, busy, w_en, done, flag_z, flag_c} !== 6'b0 ||
            {a_sel, b_sel, w_sel, w_data} !== 25'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: ready/busy/wen/done/z/c=%b a_sel=%0d b_sel=%0d w_sel=%0d w_data=%h, required all 0",
                     {cmd_ready, busy, w_en, done, flag_z, flag_c}, a_sel, b_sel, w_sel, w_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        repeat (4) begin
            @(negedge clk);
            if (w_en) stray++;
        end
        checks++;
        if (stray !== 0 || rf[6] !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_dropped: stray_wen=%0d r6=%h, required 0 0000", stray, rf[6]);
        end
    endtask

    task automatic test_all_ops();
        logic [2:0]  ops [8];
        logic [15:0] exp_d [8];
        logic        exp_c [8];
        ops   = '{ADD, SUB, AND_, OR_, XOR_, MOV, LDI, SHL1};
        exp_d = '{16'h1333, 16'h1135, 16'h0034, 16'h12FF, 16'h12CB, 16'h1234, 16'h005A, 16'h2468};
        exp_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_op(LDI, 3'd1, 3'd0, 3'd0, 8'h12, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        repeat (8) run_op(SHL1, 3'd1, 3'd1, 3'd0, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        run_op(LDI, 3'd2, 3'd0, 3'd0, 8'h34, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        run_op(OR_, 3'd1, 3'd1, 3'd2, 8'h00, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        run_op(LDI, 3'd2, 3'd0, 3'd0, 8'hFF, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
        checks++;
        if (rf[1] !== 16'h1234 || rf[2] !== 16'h00FF) begin
            errors++;
            $display("FAIL ops_setup: r1=%h r2=%h, required 1234 00ff", rf[1], rf[2]);
        end
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], 3'd7, 3'd1, 3'd2, 8'h5A, r_data, r_sel, r_done, r_z, r_c, r_k, r_p, r_ready);
            checks++;
            if (r_data !== exp_d[i] || r_c !== exp_c[i] || r_sel !== 3'd7 || r_k !== 3) begin
                errors++;
                $display("FAIL op_%0d: w_data=%h c=%b w_sel=%0d wen_cycle=%0d, required %h %b 7 3",
                         ops[i], r_data, r_c, r_sel, r_k, exp_d[i], exp_c[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add_carry();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_all_ops();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Command-driven initiator for the 8x16 two-read/one-write register file.
- Accepts one register-to-register or immediate operation per handshake, reads operands through the regfile read ports, computes the result, and writes it back through the write port.
- Sits between the instruction source (test stimulus or later control unit) and Regfile. Its outputs connect directly to Regfile a_sel/b_sel/w_data/w_sel/w_en, and its inputs to a_data/b_data.

Parameters:
DATA_W, 16, regfile word width
SEL_W, 3, register select width (2**SEL_W registers)
IMM_W, 8, immediate width for LDI

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 LDI, 7 SHL1
cmd_rd  input  SEL_W  destination register
cmd_rs  input  SEL_W  source A
cmd_rt  input  SEL_W  source B
cmd_imm  input  IMM_W  immediate for LDI
a_sel  output  SEL_W  regfile read port A select
b_sel  output  SEL_W  regfile read port B select
a_data  input  DATA_W  regfile read port A data, combinational from a_sel
b_data  input  DATA_W  regfile read port B data, combinational from b_sel
w_data  output  DATA_W  regfile write data
w_sel  output  SEL_W  regfile write select
w_en  output  1  regfile write enable, one-cycle pulse
done  output  1  one-cycle pulse coincident with w_en
busy  output  1  high in every state except IDLE
flag_z  output  1  last result == 0
flag_c  output  1  ADD carry-out / SUB borrow / SHL1 shifted-out bit

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state IDLE; a_sel=0, b_sel=0, w_data=0, w_sel=0, w_en=0, done=0, busy=0, flag_z=0, flag_c=0. cmd_ready=0 while rst is high.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- cmd_ready = (state==IDLE) && !rst.
- Accept: occurs when cmd_valid && cmd_ready at a rising edge. op, rd, rs, rt and imm are latched; state goes to READ.
- READ: a_sel=rs_latched and b_sel=rt_latched are driven as registered outputs. Selects are held from READ through WB, then remain at their last value.
- EXEC: a_data/b_data are sampled, the result is computed into a DATA_W register, and the carry is computed.
- Ops, all modulo 2**DATA_W:
  - ADD: a+b; c = carry-out.
  - SUB: a-b; c = 1 iff a<b unsigned.
  - AND / OR / XOR: bitwise; c = 0.
  - MOV: a; c = 0.
  - LDI: zero-extended imm; c = 0; rs/rt ignored.
  - SHL1: a<<1; c = a[DATA_W-1].
- WB: w_en=1, w_sel=rd_latched, w_data=result, done=1 for exactly one cycle. flag_z and flag_c update on the edge ending EXEC and hold until the next op.
- Latency: accept edge at cycle N; w_en high during cycle N+3; the regfile is written at the edge ending N+3; cmd_ready is high again in cycle N+4.
- Throughput: one op per 4 cycles. The next op's READ occurs after the previous write lands, so no read-after-write hazard exists and no bypass is needed.
- cmd_valid while busy is ignored; the command is not latched. The source holds it until cmd_ready.
- Command inputs are don't-care when cmd_valid=0.
- rd may equal rs or rt: operands were captured in EXEC, so the result is correct.
- Register 0 is an ordinary writable register; there is no hard-wired zero.
- Reset mid-operation: on the next edge with rst=1, return to IDLE. w_en/done are forced to 0 and the pending write is dropped. Flags and outputs return to reset values.
- w_en never asserts outside WB.

Test Plan:
- Reset then LDI rd=1 imm=8'hF0 -> w_en pulse 3 cycles after accept with w_sel=1, w_data=16'h00F0, done=1, flag_z=0; cmd_ready low for 3 cycles, high on cycle 4.
- LDI r2=8'hFF, LDI r3=8'h01, then SHL1 r2 repeated eight times to reach 16'hFF00; ADD rd=4 rs=2 rt=3 -> r4=16'hFF01, flag_c=0. Then preload r5=16'hFFFF via LDI/SHL1/OR and ADD r6=r5+r3 -> w_data=16'h0000, flag_z=1, flag_c=1.
- SUB rd=7 rs=3 rt=2 (1 - 16'hFF00) -> w_data=16'h0101, flag_c=1. SUB rd=3 rs=3 rt=3 -> 16'h0000, flag_z=1, flag_c=0 (rd aliases sources).
- cmd_valid held high with a second command during busy -> only the first is executed. The second is accepted on the first cycle cmd_ready=1, and exactly one w_en pulse is seen per accepted command.
- rst asserted during EXEC of ADD -> no w_en pulse; outputs at reset values on the next cycle; cmd_ready returns 1 after rst deasserts. Read r-dest via Regfile: unchanged.
- All eight opcodes against the same r1=16'h1234 / r2=16'h00FF -> ADD 16'h1333, SUB 16'h1135, AND 16'h0034, OR 16'h12FF, XOR 16'h12CB, MOV 16'h1234, SHL1 16'h2468 (c=0). Every w_data must match.
